// File: rtl/cfg_pkg.sv
// Shared definitions for the configuration loader: tile frame geometry, field positions and FSM states.
// The frame length grows by one parity slot when CFG_LOADER_PARITY_EN is defined.
package cfg_pkg;

  localparam int TILE_BITS = 77;

  // Field layout inside one tile frame (LSB positions and widths)
  localparam int CLB_LSB    = 54;
  localparam int CLB_W      = 23;
  localparam int CBLK_BL_LSB = 36;
  localparam int CBLK_TR_LSB = 18;
  localparam int CBLK_W     = 18;
  localparam int SBLK_LSB   = 0;
  localparam int SBLK_W     = 18;

`ifdef CFG_LOADER_PARITY_EN
  localparam int FRAME_EXTRA = 1;
`else
  localparam int FRAME_EXTRA = 0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } cfg_state_e;

endpackage

// File: rtl/cfg_frame_sr.sv
// MSB-first frame shift register feeding the tile bits bus, with the even parity of its contents.
// Contents only move on shift_en_i so the tiles see stable data between accepted bits.
module cfg_frame_sr
  import cfg_pkg::*;
#(
  parameter int WIDTH = cfg_pkg::TILE_BITS
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             shift_en_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] frame_o,
  output logic             parity_o
);

  logic [WIDTH-1:0] r_frame;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_frame <= '0;
    end else if (shift_en_i) begin
      r_frame <= {r_frame[WIDTH-2:0], bit_i};
    end
  end

  // Once a full frame has shifted in, the register holds exactly that frame's bits.
  assign parity_o = ^r_frame;
  assign frame_o  = r_frame;

endmodule

// File: rtl/cfg_loader.sv
// Serial configuration loader: assembles one frame per tile and pulses a one-hot write enable per tile.
// Build macro CFG_LOADER_PARITY_EN adds a trailing even-parity bit per frame; a mismatch aborts to DONE with err_o.
module cfg_loader
  import cfg_pkg::*;
#(
  parameter int NUM_TILES = 4,
  parameter int TILE_BITS = cfg_pkg::TILE_BITS
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 bit_i,
  input  logic                 bit_valid_i,
  output logic                 bit_ready_o,
  output logic [TILE_BITS-1:0] bits_o,
  output logic [NUM_TILES-1:0] wr_en_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
);

  localparam int FRAME_LEN = TILE_BITS + FRAME_EXTRA;
  localparam int CNT_W     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int IDX_W     = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;

  cfg_state_e       r_state;
  cfg_state_e       w_next;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [IDX_W-1:0] r_tile_idx;
  logic             w_restart;
  logic             w_accept;
  logic             w_last;
  logic             w_last_tile;
  logic             w_shift_en;
  logic             w_parity;
  logic             w_par_fail;

  assign w_restart   = ((r_state == S_IDLE) || (r_state == S_DONE)) && start_i;
  assign w_accept    = bit_valid_i && (r_state == S_SHIFT);
  assign w_last      = w_accept && (r_bit_cnt == CNT_W'(FRAME_LEN - 1));
  assign w_last_tile = (r_tile_idx == IDX_W'(NUM_TILES - 1));

`ifdef CFG_LOADER_PARITY_EN
  logic r_err;

  // The parity bit occupies the count slot after the frame; it is checked, never stored.
  assign w_shift_en = w_accept && (r_bit_cnt != CNT_W'(TILE_BITS));
  assign w_par_fail = w_last && (bit_i != w_parity);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err <= 1'b0;
    end else if (w_restart) begin
      r_err <= 1'b0;
    end else if (w_par_fail) begin
      r_err <= 1'b1;
    end
  end

  assign err_o = r_err;
`else
  logic w_unused_parity;

  assign w_unused_parity = w_parity;
  assign w_shift_en      = w_accept;
  assign w_par_fail      = 1'b0;
  assign err_o           = 1'b0;
`endif

  cfg_frame_sr #(
    .WIDTH(TILE_BITS)
  ) u_frame_sr (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .shift_en_i (w_shift_en),
    .bit_i      (bit_i),
    .frame_o    (bits_o),
    .parity_o   (w_parity)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start_i) w_next = S_SHIFT;
      end
      S_SHIFT: begin
        if (w_last) w_next = w_par_fail ? S_DONE : S_WRITE;
      end
      S_WRITE: begin
        w_next = w_last_tile ? S_DONE : S_SHIFT;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_bit_cnt  <= '0;
      r_tile_idx <= '0;
    end else if (w_restart) begin
      r_bit_cnt  <= '0;
      r_tile_idx <= '0;
    end else begin
      if (w_accept) begin
        r_bit_cnt <= w_last ? '0 : r_bit_cnt + CNT_W'(1);
      end
      if ((r_state == S_WRITE) && !w_last_tile) begin
        r_tile_idx <= r_tile_idx + IDX_W'(1);
      end
    end
  end

  // Outputs decode registered state only, so no input reaches an output combinationally.
  assign bit_ready_o = (r_state == S_SHIFT);
  assign busy_o      = (r_state == S_SHIFT) || (r_state == S_WRITE);
  assign done_o      = (r_state == S_DONE);
  assign wr_en_o     = (r_state == S_WRITE) ? (NUM_TILES'(1) << r_tile_idx) : '0;

endmodule

// File: tb/tb_cfg_loader.sv
// Self-checking bench for cfg_loader: a two-tile instance for the main scenarios and a one-tile instance.
// Build with CFG_LOADER_PARITY_EN defined to also cover the parity abort path.
module tb_cfg_loader;

  localparam int TB = 77;
`ifdef CFG_LOADER_PARITY_EN
  localparam int FL = TB + 1;
`else
  localparam int FL = TB;
`endif
  localparam logic [83:0]   F0_RAW = 84'h1_2345_6789_ABCD_EF01_2345;
  localparam logic [TB-1:0] F0     = F0_RAW[TB-1:0];
  localparam logic [TB-1:0] F1     = 77'd1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic          start = 1'b0, bit_in = 1'b0, bval = 1'b0;
  logic          bready, busy, done, err;
  logic [TB-1:0] bits;
  logic [1:0]    wr_en;

  logic          start1 = 1'b0, bit1 = 1'b0, bval1 = 1'b0;
  logic          bready1, busy1, done1, err1;
  logic [TB-1:0] bits1;
  logic [0:0]    wr1;

  cfg_loader #(.NUM_TILES(2), .TILE_BITS(TB)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .bit_i(bit_in), .bit_valid_i(bval),
    .bit_ready_o(bready), .bits_o(bits), .wr_en_o(wr_en), .busy_o(busy), .done_o(done), .err_o(err)
  );

  cfg_loader #(.NUM_TILES(1), .TILE_BITS(TB)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start1), .bit_i(bit1), .bit_valid_i(bval1),
    .bit_ready_o(bready1), .bits_o(bits1), .wr_en_o(wr1), .busy_o(busy1), .done_o(done1), .err_o(err1)
  );

  int n_chk = 0;
  int n_fail = 0;

  typedef struct { logic [1:0] we; logic [TB-1:0] data; } wr_t;
  wr_t           obs_q[$];
  int            hold_bad = 0;
  int            ready_bad = 0;
  logic          chk_hold = 1'b0;
  logic [TB-1:0] last_w;

  // Record every write pulse and whether the bus stayed put through the following cycle.
  always @(negedge clk) begin
    if (chk_hold) begin
      if (bits !== last_w) hold_bad++;
      chk_hold = 1'b0;
    end
    if (wr_en !== 2'b00) begin
      obs_q.push_back('{we: wr_en, data: bits});
      last_w   = bits;
      chk_hold = 1'b1;
      if (bready !== 1'b0 || busy !== 1'b1) ready_bad++;
    end
  end

  function automatic logic [TB-1:0] rand_frame();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[TB-1:0];
  endfunction

  // Serial source: MSB first, optional parity bit, holds data until the loader accepts it.
  task automatic drive2(input logic [TB-1:0] fr[$], input int gap_pct, input int bad_frame,
                        input int max_bits);
    logic bq[$];
    logic acc;
    int   sent = 0;
    int   budget = 5000;
    for (int f = 0; f < fr.size(); f++) begin
      for (int b = TB - 1; b >= 0; b--) bq.push_back(fr[f][b]);
`ifdef CFG_LOADER_PARITY_EN
      bq.push_back((^fr[f]) ^ (f == bad_frame));
`endif
    end
    while (bq.size() > 0 && sent < max_bits && budget > 0) begin
      @(negedge clk);
      bval   = ($urandom_range(99) >= gap_pct);
      bit_in = bval ? bq[0] : 1'($urandom_range(1));
      acc    = bval && bready;
      @(posedge clk);
      if (acc) begin
        void'(bq.pop_front());
        sent++;
      end
      budget--;
    end
    @(negedge clk);
    bval = 1'b0;
    n_chk++;
    if (budget <= 0) begin
      n_fail++;
      $display("FAIL drive_timeout: %0d bits sent, %0d still queued", sent, bq.size());
    end
  endtask

  task automatic start_pulse();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int c = 0;
    while (done !== 1'b1 && c < limit) begin
      @(negedge clk);
      c++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (bits !== '0 || wr_en !== 2'b00 || bready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: bits=%h we=%b rdy=%b busy=%b done=%b err=%b, want all 0",
               bits, wr_en, bready, busy, done, err);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++;
    if (bready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_hold: rdy=%b busy=%b done=%b, want 0 0 0", bready, busy, done);
    end
  endtask

  task automatic test_basic();
    logic [TB-1:0] fr[$];
    int cyc = 0;
    fr = '{F0, F1};
    obs_q.delete(); hold_bad = 0; ready_bad = 0;
    @(negedge clk);
    start = 1'b1;
    fork
      drive2(fr, 0, -1, 1000);
      begin
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 400) begin
          @(negedge clk);
          cyc++;
        end
      end
    join
    n_chk++;
    if (cyc != 1 + 2 * (FL + 1)) begin
      n_fail++;
      $display("FAIL basic_latency: done after %0d cycles, want %0d", cyc, 1 + 2 * (FL + 1));
    end
    n_chk++;
    if (obs_q.size() != 2) begin
      n_fail++;
      $display("FAIL basic_count: %0d writes, want 2", obs_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < 2; i++) begin
      n_chk++;
      if (obs_q[i].we !== 2'(1 << i) || obs_q[i].data !== fr[i]) begin
        n_fail++;
        $display("FAIL basic_write%0d: we=%b data=%h, want we=%b data=%h",
                 i, obs_q[i].we, obs_q[i].data, 2'(1 << i), fr[i]);
      end
    end
    n_chk++;
    if (hold_bad != 0 || ready_bad != 0 || busy !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_status: hold_bad=%0d ready_bad=%0d busy=%b err=%b, want 0 0 0 0",
               hold_bad, ready_bad, busy, err);
    end
  endtask

  task automatic test_gaps();
    logic [TB-1:0] fr[$];
    fr = '{rand_frame(), rand_frame()};
    obs_q.delete(); hold_bad = 0; ready_bad = 0;
    start_pulse();
    n_chk++;
    if (done !== 1'b0 || bready !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_from_done: done=%b rdy=%b, want 0 1", done, bready);
    end
    drive2(fr, 50, -1, 1000);
    wait_done(50);
    n_chk++;
    if (done !== 1'b1 || obs_q.size() != 2) begin
      n_fail++;
      $display("FAIL gaps_done: done=%b writes=%0d, want 1 and 2", done, obs_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < 2; i++) begin
      n_chk++;
      if (obs_q[i].we !== 2'(1 << i) || obs_q[i].data !== fr[i]) begin
        n_fail++;
        $display("FAIL gaps_write%0d: we=%b data=%h, want we=%b data=%h",
                 i, obs_q[i].we, obs_q[i].data, 2'(1 << i), fr[i]);
      end
    end
    n_chk++;
    if (hold_bad != 0 || ready_bad != 0) begin
      n_fail++;
      $display("FAIL gaps_handshake: hold_bad=%0d ready_bad=%0d, want 0 0", hold_bad, ready_bad);
    end
  endtask

  task automatic test_start_ignored();
    logic [TB-1:0] fr[$];
    logic rdy_seen;
    fr = '{rand_frame(), rand_frame()};
    obs_q.delete();
    start_pulse();
    fork
      drive2(fr, 0, -1, 1000);
      begin
        repeat (10) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        rdy_seen = bready;
        repeat (89) @(negedge clk);
        start = 1'b0;
      end
    join
    n_chk++;
    if (rdy_seen !== 1'b1) begin
      n_fail++;
      $display("FAIL start_in_shift: rdy=%b, want 1", rdy_seen);
    end
    wait_done(50);
    repeat (3) @(negedge clk);
    n_chk++;
    if (done !== 1'b1 || obs_q.size() != 2) begin
      n_fail++;
      $display("FAIL start_ignored_done: done=%b writes=%0d, want 1 and 2", done, obs_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < 2; i++) begin
      n_chk++;
      if (obs_q[i].we !== 2'(1 << i) || obs_q[i].data !== fr[i]) begin
        n_fail++;
        $display("FAIL start_ignored_write%0d: we=%b data=%h, want we=%b data=%h",
                 i, obs_q[i].we, obs_q[i].data, 2'(1 << i), fr[i]);
      end
    end
  endtask

  task automatic test_midreset();
    logic [TB-1:0] fr[$];
    fr = '{rand_frame(), rand_frame()};
    obs_q.delete();
    start_pulse();
    drive2(fr, 25, -1, FL + 40);
    n_chk++;
    if (obs_q.size() != 1 || (obs_q.size() == 1 && (obs_q[0].we !== 2'b01 || obs_q[0].data !== fr[0]))) begin
      n_fail++;
      $display("FAIL midreset_first: writes=%0d, want 1 write of %h to tile 0", obs_q.size(), fr[0]);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (bits !== '0 || wr_en !== 2'b00 || bready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_async: bits=%h we=%b rdy=%b busy=%b done=%b err=%b, want all 0",
               bits, wr_en, bready, busy, done, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    fr = '{rand_frame(), rand_frame()};
    obs_q.delete();
    start_pulse();
    drive2(fr, 25, -1, 1000);
    wait_done(50);
    n_chk++;
    if (done !== 1'b1 || obs_q.size() != 2) begin
      n_fail++;
      $display("FAIL reload_done: done=%b writes=%0d, want 1 and 2", done, obs_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < 2; i++) begin
      n_chk++;
      if (obs_q[i].we !== 2'(1 << i) || obs_q[i].data !== fr[i]) begin
        n_fail++;
        $display("FAIL reload_write%0d: we=%b data=%h, want we=%b data=%h",
                 i, obs_q[i].we, obs_q[i].data, 2'(1 << i), fr[i]);
      end
    end
  endtask

`ifdef CFG_LOADER_PARITY_EN
  task automatic test_parity();
    logic [TB-1:0] fr[$];
    fr = '{F0};
    obs_q.delete();
    start_pulse();
    drive2(fr, 0, 0, 1000);
    wait_done(20);
    n_chk++;
    if (obs_q.size() != 0 || err !== 1'b1 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL parity_abort: writes=%0d err=%b done=%b, want 0 1 1", obs_q.size(), err, done);
    end
    start_pulse();
    n_chk++;
    if (err !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL parity_clear: err=%b done=%b, want 0 0", err, done);
    end
    fr = '{rand_frame(), rand_frame()};
    drive2(fr, 30, -1, 1000);
    wait_done(50);
    n_chk++;
    if (obs_q.size() != 2 || err !== 1'b0 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL parity_good: writes=%0d err=%b done=%b, want 2 0 1", obs_q.size(), err, done);
    end
  endtask
`endif

  task automatic test_single_tile();
    int cyc = 1;
    int pulses = 0;
    int bad = 0;
    @(negedge clk);
    start1 = 1'b1;
    bval1  = 1'b1;
    bit1   = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    while (done1 !== 1'b1 && cyc < 300) begin
      if (wr1 !== 1'b0) begin
        pulses++;
        if (bits1 !== {TB{1'b1}} || bready1 !== 1'b0) bad++;
      end
      @(negedge clk);
      cyc++;
    end
    bval1 = 1'b0;
    n_chk++;
    if (pulses != 1 || bad != 0) begin
      n_fail++;
      $display("FAIL single_write: pulses=%0d bad=%0d, want 1 0", pulses, bad);
    end
    n_chk++;
    if (done1 !== 1'b1 || cyc != 1 + (FL + 1) || err1 !== 1'b0 || busy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done: done=%b cycles=%0d err=%b busy=%b, want 1 %0d 0 0",
               done1, cyc, err1, busy1, 1 + (FL + 1));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_start_ignored();
    test_midreset();
`ifdef CFG_LOADER_PARITY_EN
    test_parity();
`endif
    test_single_tile();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
